// File: rtl/sw_btn_reader_pkg.sv
// sw_btn_reader_pkg: widths, read-select encodings and field offsets shared with the bus decoder
package sw_btn_reader_pkg;
    localparam int SW_W  = 24;
    localparam int BTN_W = 5;
    localparam int IN_W  = SW_W + BTN_W;
    localparam logic SEL_SW  = 1'b0;
    localparam logic SEL_BTN = 1'b1;
    localparam int BTN_PEND_LSB = 0;
    localparam int BTN_LVL_LSB  = 8;
    function automatic logic [31:0] btn_word(logic [BTN_W-1:0] lvl, logic [BTN_W-1:0] pend);
        logic [31:0] w;
        w = '0;
        w[BTN_LVL_LSB +: BTN_W]  = lvl;
        w[BTN_PEND_LSB +: BTN_W] = pend;
        return w;
    endfunction
endpackage

// File: rtl/sw_btn_reader_debounce_bit.sv
// debounce_bit: 2-flop synchronizer plus two-tick agreement filter for one input bit
module debounce_bit (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic din,
    output logic dout
);
    logic s1_q, s1_d, s2_q, s2_d, samp_q, samp_d, stable_q, stable_d;
    // sync chain shifts every cycle; samp/stable only move on a tick, stable only when two ticks agree
    always_comb begin
        s1_d     = din;
        s2_d     = s1_q;
        samp_d   = tick ? s2_q : samp_q;
        stable_d = (tick && s2_q == samp_q) ? s2_q : stable_q;
    end
    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            samp_q   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            samp_q   <= samp_d;
            stable_q <= stable_d;
        end
    end
    assign dout = stable_q;
endmodule

// File: rtl/sw_btn_reader.sv
// sw_btn_reader: debounced switch/button input register with sticky button-press flags
module sw_btn_reader
    import sw_btn_reader_pkg::*;
#(
    parameter int DB_TICK = 1_000_000,
    parameter int DB_CW   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   sw,
    input  logic [BTN_W-1:0]  btn,
    input  logic              rd_en,
    input  logic              rd_sel,
    output logic [31:0]       rdata,
    output logic              rvalid
);
    logic [DB_CW-1:0] cnt_q, cnt_d;
    logic             tick;
    logic [IN_W-1:0]  stable;
    logic [SW_W-1:0]  stable_sw;
    logic [BTN_W-1:0] stable_btn, stable_btn_d_q, stable_btn_d_d, pend_q, pend_d, btn_rise;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d, rd_btn;

    assign tick = (cnt_q == DB_CW'(DB_TICK - 1));

    for (genvar g = 0; g < IN_W; g++) begin : g_db
        debounce_bit u_db (
            .clk  (clk),
            .rst  (rst),
            .tick (tick),
            .din  (g < SW_W ? sw[g % SW_W] : btn[(g - SW_W) % BTN_W]),
            .dout (stable[g])
        );
    end

    assign stable_sw  = stable[SW_W-1:0];
    assign stable_btn = stable[IN_W-1:SW_W];
    assign btn_rise   = stable_btn & ~stable_btn_d_q;
    assign rd_btn     = rd_en && (rd_sel == SEL_BTN);

    // free-running tick counter, edge detect, sticky pend (a same-cycle rise beats the clear) and read mux
    always_comb begin
        cnt_d          = tick ? '0 : cnt_q + DB_CW'(1);
        stable_btn_d_d = stable_btn;
        pend_d         = (rd_btn ? '0 : pend_q) | btn_rise;
        rdata_d        = !rd_en ? rdata_q
                       : (rd_sel == SEL_BTN) ? btn_word(stable_btn, pend_q)
                       : {8'h00, stable_sw};
        rvalid_d       = rd_en;
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q          <= '0;
            stable_btn_d_q <= '0;
            pend_q         <= '0;
            rdata_q        <= '0;
            rvalid_q       <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            stable_btn_d_q <= stable_btn_d_d;
            pend_q         <= pend_d;
            rdata_q        <= rdata_d;
            rvalid_q       <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
endmodule

// File: tb/tb_sw_btn_reader.sv
// tb_sw_btn_reader: directed scoreboard bench for sw_btn_reader with DB_TICK=4
module tb_sw_btn_reader;
    import sw_btn_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic        rd_en;
    logic        rd_sel;
    logic [31:0] rdata;
    logic        rvalid;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        chk_on  = 1'b1;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    sw_btn_reader #(.DB_TICK(4), .DB_CW(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .sw     (sw),
        .btn    (btn),
        .rd_en  (rd_en),
        .rd_sel (rd_sel),
        .rdata  (rdata),
        .rvalid (rvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic sel, input logic [31:0] exp, input string tag);
        rd_en  = 1'b1;
        rd_sel = sel;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        cyc(1);
        rd_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_on && rvalid === 1'b1) begin
            if (exp_q.size() == 0) chk("rvalid_extra", 32'(rvalid), 32'h0);
            else chk(tag_q.pop_front(), rdata, exp_q.pop_front());
        end
    end

    initial begin
        logic found;
        rst = 1'b0; sw = 24'hFFFFFF; btn = '0; rd_en = 1'b0; rd_sel = SEL_SW;
        cyc(3);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        rst = 1'b1;
        sw  = 24'hA5A5A5;
        rd(SEL_SW, 32'h0, "sw_unstable");
        cyc(10);
        rd(SEL_SW, 32'h00A5A5A5, "sw_step");
        cyc(2);
        btn[2] = 1'b1;
        cyc(2);
        btn[2] = 1'b0;
        cyc(12);
        rd(SEL_BTN, 32'h0, "glitch");
        btn[0] = 1'b1;
        cyc(20);
        rd(SEL_BTN, 32'h00000101, "held_read");
        rd(SEL_BTN, 32'h00000100, "held_reread");
        btn[0] = 1'b0;
        cyc(12);
        rd(SEL_BTN, 32'h0, "released");
        btn[0] = 1'b1;
        cyc(20);
        btn[0] = 1'b0;
        cyc(12);
        rd(SEL_SW, 32'h00A5A5A5, "sw_keeps_pend");
        rd(SEL_BTN, 32'h00000001, "sticky");
        rd(SEL_BTN, 32'h0, "sticky_cleared");
        cyc(3);
        chk_on = 1'b0;
        btn[3] = 1'b1;
        rd_en  = 1'b1;
        rd_sel = SEL_BTN;
        found  = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1);
            found = (rdata != 32'h0);
        end
        chk("race_seen", 32'(found), 32'h1);
        chk("race_read", rdata, 32'h00000800);
        cyc(1);
        chk("race_next", rdata, 32'h00000808);
        rd_en = 1'b0;
        cyc(2);
        chk_on = 1'b1;
        btn[3] = 1'b0;
        cyc(12);
        rd(SEL_BTN, 32'h0, "race_released");
        btn = 5'b10001;
        cyc(20);
        btn = 5'b00000;
        cyc(12);
        rd(SEL_SW, 32'h00A5A5A5, "pre_reset_sw");
        rst    = 1'b0;
        rd_en  = 1'b1;
        rd_sel = SEL_BTN;
        cyc(1);
        chk("midreset_rdata", rdata, 32'h0);
        chk("midreset_rvalid", 32'(rvalid), 32'h0);
        rst   = 1'b1;
        rd_en = 1'b0;
        rd(SEL_BTN, 32'h0, "post_reset_btn");
        rd(SEL_SW, 32'h0, "post_reset_sw");
        cyc(8);
        rd(SEL_SW, 32'h00A5A5A5, "redebounced_sw");
        rd(SEL_BTN, 32'h0, "redebounced_btn");
        cyc(3);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
